// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
// -----------------------------------------------------------------------------
// Serialises the 16-bit signed synth voice sample into a Philips I2S stream for
// the board audio codec. The block divides clk down to MCLK (clk/4), SCLK and
// LRCLK. LRCLK is the sample-rate clock that steps the synth's phase
// accumulators. The source is mono, so the same word goes out in the left and
// right slots. Each frame is 64 SCLK periods, which is 128*SCLK_HALF clk cycles.
//
// Parameters
//   SCLK_HALF    clk cycles per SCLK half-period (>= 1)
//
// Ports
//   clk          in   1   system clock; all logic on posedge clk
//   Reset_n      in   1   synchronous, active-low reset
//   sample_in    in   16  signed PCM sample; sampled only at the capture point
//   atten        in   3   arithmetic right-shift attenuation, 0 = full scale
//   mute         in   1   1 = capture zero instead of sample_in
//   I2S_MCLK     out  1   codec master clock, clk/4, 50% duty
//   I2S_SCLK     out  1   bit clock
//   I2S_LRCLK    out  1   word select: 0 = left slot, 1 = right slot
//   I2S_DOUT     out  1   serial data; changes on the SCLK falling edge
//   frame_start  out  1   one-clk pulse when LRCLK goes 1->0 (new frame)
//
// Every output is a flop, so there is no combinational path from any input to
// any output. The transmitter free-runs and has no handshake.
// -----------------------------------------------------------------------------
module i2s_tx #(
    parameter int SCLK_HALF = 8
) (
    input  logic        clk,
    input  logic        Reset_n,
    input  logic [15:0] sample_in,
    input  logic [2:0]  atten,
    input  logic        mute,
    output logic        I2S_MCLK,
    output logic        I2S_SCLK,
    output logic        I2S_LRCLK,
    output logic        I2S_DOUT,
    output logic        frame_start
);

    // A 1-bit divider is enough when SCLK_HALF is 1. It then sits at 0 and
    // wraps on every clk.
    localparam int               DIV_W    = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);

    // Bit positions inside a frame.
    localparam logic [5:0] POS_FRAME = 6'd0;   // left slot begins, word loaded
    localparam logic [5:0] POS_RIGHT = 6'd32;  // right slot begins, sample captured

    // State
    logic [DIV_W-1:0]   div_cnt;
    logic [1:0]         mclk_cnt;
    logic [5:0]         bit_cnt;
    logic signed [15:0] sample_q;   // captured and attenuated sample
    logic [15:0]        out_word;   // word being shifted out in this frame

    // Next-state values
    logic [DIV_W-1:0]   div_cnt_nxt;
    logic [1:0]         mclk_cnt_nxt;
    logic [5:0]         bit_cnt_nxt;
    logic signed [15:0] sample_q_nxt;
    logic [15:0]        out_word_nxt;
    logic               sclk_nxt;
    logic               lrclk_nxt;
    logic               dout_nxt;
    logic               frame_start_nxt;

    // Decode
    logic               div_wrap;
    logic               fall_evt;
    logic [5:0]         bit_cnt_inc;
    logic [4:0]         slot_pos;
    logic [3:0]         word_idx;
    logic               slot_bit;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default value first.
        // Any path that leaves a signal unassigned would infer a latch.
        div_cnt_nxt     = div_cnt;
        mclk_cnt_nxt    = mclk_cnt + 2'd1;
        bit_cnt_nxt     = bit_cnt;
        sample_q_nxt    = sample_q;
        out_word_nxt    = out_word;
        sclk_nxt        = I2S_SCLK;
        lrclk_nxt       = I2S_LRCLK;
        dout_nxt        = I2S_DOUT;
        frame_start_nxt = 1'b0;

        // SCLK divider. SCLK toggles on each wrap. A wrap while SCLK is high
        // is the falling edge, and every bit-level action happens on it.
        div_wrap = (div_cnt == DIV_LAST);
        fall_evt = div_wrap && I2S_SCLK;

        if (div_wrap) begin
            div_cnt_nxt = '0;
            sclk_nxt    = ~I2S_SCLK;
        end else begin
            div_cnt_nxt = div_cnt + DIV_W'(1);
        end

        // Data bit for the position that is about to start. Slot position 0
        // is the I2S one-bit delay, positions 1..16 carry the word MSB first,
        // and positions 17..31 are zero padding. word_idx only matters inside
        // 1..16; outside that range it wraps and is ignored.
        bit_cnt_inc = bit_cnt + 6'd1;
        slot_pos    = bit_cnt_inc[4:0];
        word_idx    = 4'(5'd16 - slot_pos);
        slot_bit    = (slot_pos != 5'd0 && slot_pos <= 5'd16) ? out_word[word_idx] : 1'b0;

        if (fall_evt) begin
            bit_cnt_nxt = bit_cnt_inc;
            lrclk_nxt   = bit_cnt_inc[5];
            dout_nxt    = slot_bit;

            // Capture at the start of the right slot. This is half a frame
            // after the synth updates on the LRCLK falling edge, so its output
            // has settled by now.
            if (bit_cnt_inc == POS_RIGHT) begin
                sample_q_nxt = mute ? 16'sd0 : ($signed(sample_in) >>> atten);
            end

            // The new word takes effect at the frame boundary. Both slots of
            // the frame then carry the same word.
            if (bit_cnt_inc == POS_FRAME) begin
                out_word_nxt    = sample_q;
                frame_start_nxt = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop then
        // samples values from before the edge, whatever the statement order.
        if (!Reset_n) begin
            div_cnt     <= '0;
            mclk_cnt    <= '0;
            bit_cnt     <= '0;
            sample_q    <= '0;
            out_word    <= '0;
            I2S_MCLK    <= 1'b0;
            I2S_SCLK    <= 1'b0;
            I2S_LRCLK   <= 1'b0;
            I2S_DOUT    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_cnt_nxt;
            mclk_cnt    <= mclk_cnt_nxt;
            bit_cnt     <= bit_cnt_nxt;
            sample_q    <= sample_q_nxt;
            out_word    <= out_word_nxt;
            I2S_MCLK    <= mclk_cnt_nxt[1];
            I2S_SCLK    <= sclk_nxt;
            I2S_LRCLK   <= lrclk_nxt;
            I2S_DOUT    <= dout_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx
// -----------------------------------------------------------------------------
// Directed bench for i2s_tx. dut0 uses SCLK_HALF=8 (1024-clk frame) and dut1
// uses SCLK_HALF=1 (128-clk frame). The two instances share clock, reset and
// sample inputs. Each output bit of a frame is recorded on the clk after an
// SCLK falling edge. The recorded frame is compared with the bit pattern
// expected for a hand-computed word.
// -----------------------------------------------------------------------------
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        Reset_n;
    logic [15:0] sample_in;
    logic [2:0]  atten;
    logic        mute;

    logic mclk0, sclk0, lr0, dout0, fs0;
    logic mclk1, sclk1, lr1, dout1, fs1;

    int checks = 0;
    int errors = 0;

    // LRCLK over a frame: bits 0..31 are the left slot (0), bits 32..63 are the
    // right slot (1).
    localparam logic [63:0] EXP_LR = {32'hFFFF_FFFF, 32'h0000_0000};

    always #5 clk = ~clk;

    i2s_tx #(.SCLK_HALF(8)) dut0 (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .sample_in   (sample_in),
        .atten       (atten),
        .mute        (mute),
        .I2S_MCLK    (mclk0),
        .I2S_SCLK    (sclk0),
        .I2S_LRCLK   (lr0),
        .I2S_DOUT    (dout0),
        .frame_start (fs0)
    );

    i2s_tx #(.SCLK_HALF(1)) dut1 (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .sample_in   (sample_in),
        .atten       (atten),
        .mute        (mute),
        .I2S_MCLK    (mclk1),
        .I2S_SCLK    (sclk1),
        .I2S_LRCLK   (lr1),
        .I2S_DOUT    (dout1),
        .frame_start (fs1)
    );

    // Output bundle {mclk, sclk, lrclk, dout, frame_start} of the chosen DUT.
    function automatic logic [4:0] outs(input bit which);
        return which ? {mclk1, sclk1, lr1, dout1, fs1} : {mclk0, sclk0, lr0, dout0, fs0};
    endfunction

    // Frame bit pattern for word w. In each slot, position 0 is the delay bit,
    // positions 1..16 carry w MSB first, and the rest is zero.
    function automatic logic [63:0] exp_data(input logic [15:0] w);
        logic [63:0] r;
        r = '0;
        for (int s = 0; s < 2; s++)
            for (int p = 1; p <= 16; p++)
                r[s*32 + p] = w[16 - p];
        return r;
    endfunction

    // Waits for the next frame_start and records DOUT/LRCLK for all 64 bit
    // positions. If chg_bit >= 0, sample_in is set to chg_val just after that
    // bit position starts. ok stays 0 if any wait runs out.
    task automatic get_frame(input bit which, input int chg_bit, input logic [15:0] chg_val,
                             output logic [63:0] dbits, output logic [63:0] lbits,
                             output bit ok);
        logic [4:0] o;
        logic       prev_sclk;
        logic       found;
        int         wait_n;
        dbits  = '0;
        lbits  = '0;
        ok     = 1'b0;
        wait_n = 0;
        do begin
            @(negedge clk);
            wait_n++;
            o = outs(which);
        end while (o[0] !== 1'b1 && wait_n < 3000);
        if (o[0] !== 1'b1) return;
        dbits[0]  = o[1];
        lbits[0]  = o[2];
        prev_sclk = o[3];
        for (int i = 1; i < 64; i++) begin
            found  = 1'b0;
            wait_n = 0;
            while (!found && wait_n < 100) begin
                @(negedge clk);
                wait_n++;
                o         = outs(which);
                found     = (prev_sclk === 1'b1 && o[3] === 1'b0);
                prev_sclk = o[3];
            end
            if (!found) return;
            dbits[i] = o[1];
            lbits[i] = o[2];
            if (i == chg_bit) sample_in = chg_val;
        end
        ok = 1'b1;
    endtask

    // Call this on the negedge where reset has just been released. The task
    // checks the first SCLK rise, the MCLK waveform, the all-zero first frame,
    // the frame_start timing (once per frame, one clk wide) and the LRCLK
    // period.
    task automatic observe_startup(input string tag, input bit which, input int sh);
        logic [4:0] o;
        logic       prev_lr;
        int         first_rise;
        int         mclk_bad;
        int         zeros_bad;
        int         fs_q[$];
        int         lr_q[$];
        first_rise = -1;
        mclk_bad   = 0;
        zeros_bad  = 0;
        prev_lr    = 1'b0;
        for (int n = 1; n <= 256*sh + 40; n++) begin
            @(negedge clk);
            o = outs(which);
            if (first_rise < 0 && o[3] === 1'b1) first_rise = n;
            if (o[4] !== ((n % 4) >= 2)) mclk_bad++;
            if (o[0] === 1'b1) fs_q.push_back(n);
            if (prev_lr === 1'b0 && o[2] === 1'b1) lr_q.push_back(n);
            prev_lr = o[2];
            if (fs_q.size() == 0 && o[1] !== 1'b0) zeros_bad++;
        end

        checks++;
        if (first_rise != sh) begin
            errors++;
            $display("FAIL %s_first_sclk_rise: got clk %0d, expected clk %0d", tag, first_rise, sh);
        end
        checks++;
        if (mclk_bad != 0) begin
            errors++;
            $display("FAIL %s_mclk: %0d cycles off the clk/4 pattern, expected 0", tag, mclk_bad);
        end
        checks++;
        if (zeros_bad != 0) begin
            errors++;
            $display("FAIL %s_first_frame_zero: %0d nonzero DOUT cycles, expected 0", tag, zeros_bad);
        end
        checks++;
        if (fs_q.size() != 2 || fs_q[0] != 128*sh || fs_q[1] != 256*sh) begin
            errors++;
            $display("FAIL %s_frame_start: %0d pulses, first at %0d, last at %0d, expected 2 at %0d and %0d",
                     tag, fs_q.size(), (fs_q.size() > 0) ? fs_q[0] : -1,
                     (fs_q.size() > 0) ? fs_q[fs_q.size()-1] : -1, 128*sh, 256*sh);
        end
        checks++;
        if (lr_q.size() != 2 || lr_q[0] != 64*sh || lr_q[1] != 192*sh) begin
            errors++;
            $display("FAIL %s_lrclk_period: %0d rises, first at %0d, last at %0d, expected 2 at %0d and %0d",
                     tag, lr_q.size(), (lr_q.size() > 0) ? lr_q[0] : -1,
                     (lr_q.size() > 0) ? lr_q[lr_q.size()-1] : -1, 64*sh, 192*sh);
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        sample_in = 16'h8001;
        atten     = 3'd0;
        mute      = 1'b0;
        Reset_n   = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (outs(1'b0) !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs_dut0: got %b, expected 00000", outs(1'b0));
        end
        checks++;
        if (outs(1'b1) !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs_dut1: got %b, expected 00000", outs(1'b1));
        end
        Reset_n = 1'b1;
        observe_startup("reset", 1'b0, 8);
    endtask

    task automatic test_basic();
        logic [63:0] d, l;
        bit          ok;
        get_frame(1'b0, -1, 16'h0, d, l, ok);
        checks++;
        if (!ok || d !== exp_data(16'h8001)) begin
            errors++;
            $display("FAIL basic_8001_data: ok=%0d dout=%h, expected %h", ok, d, exp_data(16'h8001));
        end
        checks++;
        if (!ok || l !== EXP_LR) begin
            errors++;
            $display("FAIL basic_8001_lrclk: ok=%0d lrclk=%h, expected %h", ok, l, EXP_LR);
        end
    endtask

    task automatic test_atten();
        logic [63:0] d, l;
        bit          ok;
        logic [15:0] vs [4];
        logic [2:0]  va [4];
        logic [15:0] vw [4];
        vs = '{16'h8000, 16'h7FFF, 16'h1234, 16'hF0F0};
        va = '{3'd7,     3'd7,     3'd4,     3'd2};
        vw = '{16'hFF00, 16'h00FF, 16'h0123, 16'hFC3C};
        for (int k = 0; k < 4; k++) begin
            sample_in = vs[k];
            atten     = va[k];
            get_frame(1'b0, -1, 16'h0, d, l, ok);   // still carries the previous capture
            get_frame(1'b0, -1, 16'h0, d, l, ok);
            checks++;
            if (!ok || d !== exp_data(vw[k])) begin
                errors++;
                $display("FAIL atten_%0d: in=%h atten=%0d ok=%0d dout=%h, expected %h",
                         k, vs[k], va[k], ok, d, exp_data(vw[k]));
            end
        end
        atten = 3'd0;
    endtask

    task automatic test_mute_hold();
        logic [63:0] d, l;
        bit          ok;
        mute      = 1'b1;
        sample_in = 16'h1234;
        get_frame(1'b0, -1, 16'h0, d, l, ok);
        get_frame(1'b0, -1, 16'h0, d, l, ok);
        checks++;
        if (!ok || d !== 64'h0) begin
            errors++;
            $display("FAIL mute_zero: ok=%0d dout=%h, expected 0", ok, d);
        end

        mute      = 1'b0;
        sample_in = 16'hA5A5;
        get_frame(1'b0, -1, 16'h0, d, l, ok);
        // sample_in changes at bit 40, which is after this frame's capture point.
        get_frame(1'b0, 40, 16'h1111, d, l, ok);
        checks++;
        if (!ok || d !== exp_data(16'hA5A5)) begin
            errors++;
            $display("FAIL hold_frame1: ok=%0d dout=%h, expected %h", ok, d, exp_data(16'hA5A5));
        end
        get_frame(1'b0, -1, 16'h0, d, l, ok);
        checks++;
        if (!ok || d !== exp_data(16'hA5A5)) begin
            errors++;
            $display("FAIL hold_frame2: ok=%0d dout=%h, expected %h", ok, d, exp_data(16'hA5A5));
        end
        get_frame(1'b0, -1, 16'h0, d, l, ok);
        checks++;
        if (!ok || d !== exp_data(16'h1111)) begin
            errors++;
            $display("FAIL hold_new_capture: ok=%0d dout=%h, expected %h", ok, d, exp_data(16'h1111));
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d, l;
        bit          ok;
        logic [4:0]  o;
        logic        prev_sclk;
        int          falls;
        int          wait_n;
        sample_in = 16'hC3C3;
        wait_n    = 0;
        do begin
            @(negedge clk);
            wait_n++;
            o = outs(1'b0);
        end while (o[0] !== 1'b1 && wait_n < 3000);
        prev_sclk = o[3];
        falls     = 0;
        while (falls < 20 && wait_n < 6000) begin
            @(negedge clk);
            wait_n++;
            o = outs(1'b0);
            if (prev_sclk === 1'b1 && o[3] === 1'b0) falls++;
            prev_sclk = o[3];
        end
        checks++;
        if (falls != 20) begin
            errors++;
            $display("FAIL midreset_align: reached %0d fall events, expected 20", falls);
        end
        Reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (outs(1'b0) !== 5'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b, expected 00000", outs(1'b0));
        end
        Reset_n = 1'b1;
        observe_startup("midreset", 1'b0, 8);
        get_frame(1'b0, -1, 16'h0, d, l, ok);
        checks++;
        if (!ok || d !== exp_data(16'hC3C3)) begin
            errors++;
            $display("FAIL midreset_resume: ok=%0d dout=%h, expected %h", ok, d, exp_data(16'hC3C3));
        end
    endtask

    task automatic test_sclk_half1();
        logic [63:0] d, l;
        bit          ok;
        sample_in = 16'h8001;
        atten     = 3'd0;
        mute      = 1'b0;
        Reset_n   = 1'b0;
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
        observe_startup("half1", 1'b1, 1);
        get_frame(1'b1, -1, 16'h0, d, l, ok);
        checks++;
        if (!ok || d !== exp_data(16'h8001)) begin
            errors++;
            $display("FAIL half1_data: ok=%0d dout=%h, expected %h", ok, d, exp_data(16'h8001));
        end
        checks++;
        if (!ok || l !== EXP_LR) begin
            errors++;
            $display("FAIL half1_lrclk: ok=%0d lrclk=%h, expected %h", ok, l, EXP_LR);
        end
        sample_in = 16'h4321;
        atten     = 3'd1;
        get_frame(1'b1, -1, 16'h0, d, l, ok);
        get_frame(1'b1, -1, 16'h0, d, l, ok);
        checks++;
        if (!ok || d !== exp_data(16'h2190)) begin
            errors++;
            $display("FAIL half1_atten: ok=%0d dout=%h, expected %h", ok, d, exp_data(16'h2190));
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        Reset_n   = 1'b0;
        sample_in = '0;
        atten     = '0;
        mute      = 1'b0;
        test_reset();
        test_basic();
        test_atten();
        test_mute_hold();
        test_reset_mid();
        test_sclk_half1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule
